// File: rtl/imem_loader.sv
// Boot-time loader: parses a byte stream (16-bit word count, then big-endian words)
// and writes it into instruction memory while holding the core in reset.
module imem_loader #(
   parameter int unsigned DEPTH     = 64,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [7:0]  in_byte,
   output logic        in_ready,
   input  logic        load_req,
   output logic        wr_en,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        core_reset,
   output logic        done,
   output logic        error,
   output logic [15:0] words_loaded
);

   typedef enum logic [2:0] {CNT_HI, CNT_LO, DATA, DONE, ERR} state_t;

   state_t      state;
   logic [15:0] cnt;
   logic [1:0]  byte_idx;
   logic [31:0] word;

   logic        accept;
   logic [15:0] cnt_full;
   logic [31:0] word_next;

   assign accept    = in_valid && in_ready;
   assign cnt_full  = {cnt[15:8], in_byte};
   assign word_next = {word[23:0], in_byte};

   // NOTE: every register here is updated with <= so all of them see the
   // pre-edge values of each other; mixing in = would create order-dependent logic.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= CNT_HI;
         cnt          <= '0;
         byte_idx     <= '0;
         word         <= '0;
         in_ready     <= 1'b0;
         wr_en        <= 1'b0;
         wr_addr      <= BASE_ADDR;
         wr_data      <= '0;
         core_reset   <= 1'b1;
         done         <= 1'b0;
         error        <= 1'b0;
         words_loaded <= '0;
      end else begin
         wr_en <= 1'b0;
         case (state)
            CNT_HI: begin
               in_ready   <= 1'b1;
               core_reset <= 1'b1;
               if (accept) begin
                  cnt[15:8] <= in_byte;
                  state     <= CNT_LO;
               end
            end

            CNT_LO: begin
               if (accept) begin
                  cnt[7:0] <= in_byte;
                  if (cnt_full == 16'd0) begin
                     state    <= DONE;
                     in_ready <= 1'b0;
                  end else if (cnt_full > 16'(DEPTH)) begin
                     state    <= ERR;
                     in_ready <= 1'b0;
                     error    <= 1'b1;
                  end else begin
                     state    <= DATA;
                     byte_idx <= 2'd0;
                  end
               end
            end

            // The write registers are separate from the assembly register, so
            // the next word can start assembling during the strobe cycle.
            DATA: begin
               if (accept) begin
                  word     <= word_next;
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     wr_en        <= 1'b1;
                     wr_data      <= word_next;
                     wr_addr      <= BASE_ADDR + {14'd0, words_loaded, 2'b00};
                     words_loaded <= words_loaded + 16'd1;
                     if (words_loaded + 16'd1 == cnt) begin
                        state    <= DONE;
                        in_ready <= 1'b0;
                     end
                  end
               end
            end

            // core_reset drops one cycle after entering DONE, after the final strobe.
            DONE: begin
               if (load_req) begin
                  state        <= CNT_HI;
                  words_loaded <= '0;
                  wr_addr      <= BASE_ADDR;
                  done         <= 1'b0;
                  core_reset   <= 1'b1;
                  in_ready     <= 1'b1;
               end else begin
                  done       <= 1'b1;
                  core_reset <= 1'b0;
                  in_ready   <= 1'b0;
               end
            end

            ERR: begin
               in_ready   <= 1'b0;
               core_reset <= 1'b1;
               error      <= 1'b1;
            end

            default: state <= CNT_HI;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised directed bench for imem_loader; a queue-based model predicts the
// writes and status each load must produce.
module tb_imem_loader;

   localparam int unsigned DEPTH = 64;
   localparam logic [31:0] BASE  = 32'h0000_0100;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [7:0]  in_byte;
   logic        in_ready;
   logic        load_req;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        core_reset;
   logic        done;
   logic        error;
   logic [15:0] words_loaded;

   imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_byte(in_byte),
      .in_ready(in_ready), .load_req(load_req), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .core_reset(core_reset), .done(done), .error(error),
      .words_loaded(words_loaded)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          fall_cyc = -1;
   wr_t         wr_q[$];
   int          acc_q[$];
   logic [31:0] words[$];
   logic [7:0]  stream[$];

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (wr_en === 1'b1) wr_q.push_back('{addr: wr_addr, data: wr_data, cyc: cyc});
      if (core_reset === 1'b0 && fall_cyc < 0) fall_cyc = cyc;
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic new_test();
      wr_q.delete();
      acc_q.delete();
      fall_cyc = -1;
   endtask

   task automatic do_reset(input string tag);
      reset    = 1'b1;
      in_valid = 1'b0;
      in_byte  = 8'h00;
      load_req = 1'b0;
      step();
      step();
      chk({tag, " rst in_ready"},     in_ready,     0);
      chk({tag, " rst wr_en"},        wr_en,        0);
      chk({tag, " rst wr_addr"},      wr_addr,      BASE);
      chk({tag, " rst wr_data"},      wr_data,      0);
      chk({tag, " rst core_reset"},   core_reset,   1);
      chk({tag, " rst done"},         done,         0);
      chk({tag, " rst error"},        error,        0);
      chk({tag, " rst words_loaded"}, words_loaded, 0);
      reset = 1'b0;
      step();
      chk({tag, " in_ready after reset"}, in_ready, 1);
   endtask

   // Stream = 16-bit count big-endian, then the queued words big-endian.
   task automatic build_stream(input int count);
      stream.delete();
      stream.push_back(8'(count >> 8));
      stream.push_back(8'(count));
      foreach (words[k]) begin
         for (int b = 3; b >= 0; b--) stream.push_back(8'(words[k] >> (8 * b)));
      end
   endtask

   task automatic send(input int nbytes, input bit gaps);
      int tries;
      bit taken;
      bit hit;
      for (int i = 0; i < nbytes; i++) begin
         tries = 0;
         taken = 1'b0;
         while (!taken) begin
            if (gaps && ($urandom_range(0, 2) == 0)) begin
               in_valid = 1'b0;
               in_byte  = 8'($urandom);
            end else begin
               in_valid = 1'b1;
               in_byte  = stream[i];
            end
            hit = in_valid && in_ready;
            step();
            if (hit) begin
               taken = 1'b1;
               acc_q.push_back(cyc);
            end else if (++tries > 64) begin
               chk("accept_timeout", 0, 1);
               in_valid = 1'b0;
               return;
            end
         end
      end
      in_valid = 1'b0;
   endtask

   // Model: a legal count yields exactly count writes at BASE+4k carrying word k.
   task automatic check_load(input string tag, input int count);
      int exp_n;
      bit bad;
      bad   = (count > int'(DEPTH));
      exp_n = bad ? 0 : count;
      for (int i = 0; i < 4; i++) step();
      chk({tag, " write count"}, wr_q.size(), exp_n);
      for (int k = 0; k < exp_n && k < wr_q.size(); k++) begin
         chk($sformatf("%s addr[%0d]", tag, k), wr_q[k].addr, BASE + 32'(4 * k));
         chk($sformatf("%s data[%0d]", tag, k), wr_q[k].data, words[k]);
      end
      chk({tag, " error"},        error,        bad);
      chk({tag, " done"},         done,         !bad);
      chk({tag, " core_reset"},   core_reset,   bad);
      chk({tag, " in_ready"},     in_ready,     0);
      chk({tag, " words_loaded"}, words_loaded, bad ? 0 : count);
   endtask

   task automatic pulse_load_req(input string tag);
      new_test();
      load_req = 1'b1;
      step();
      load_req = 1'b0;
      chk({tag, " core_reset after load_req"}, core_reset, 1);
      chk({tag, " done after load_req"},       done,       0);
      chk({tag, " words_loaded cleared"},      words_loaded, 0);
   endtask

   initial begin
      int n;

      do_reset("t0");

      // Two words, valid held high: timing of strobes and core release.
      new_test();
      words = '{32'h2001_0005, 32'h0022_1820};
      build_stream(2);
      send(stream.size(), 1'b0);
      check_load("t1", 2);
      if (wr_q.size() >= 2 && acc_q.size() == 10) begin
         chk("t1 wr0 timing", wr_q[0].cyc, acc_q[5]);
         chk("t1 wr1 timing", wr_q[1].cyc, acc_q[9]);
         chk("t1 no stall",   acc_q[9] - acc_q[0], 9);
         chk("t1 core_reset fall", fall_cyc, acc_q[9] + 1);
      end else begin
         chk("t1 strobes/accepts present", 0, 1);
      end

      // Zero count: straight to DONE.
      do_reset("t2");
      new_test();
      words.delete();
      build_stream(0);
      send(2, 1'b0);
      check_load("t2", 0);
      if (acc_q.size() == 2) chk("t2 core_reset fall", fall_cyc, acc_q[1] + 1);
      else chk("t2 accepts present", 0, 1);

      // Count above DEPTH: sticky error, load_req ignored.
      do_reset("t3");
      new_test();
      words.delete();
      build_stream(int'(DEPTH) + 1);
      send(2, 1'b0);
      check_load("t3", int'(DEPTH) + 1);
      load_req = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) step();
      load_req = 1'b0;
      in_valid = 1'b0;
      chk("t3 error held",      error,      1);
      chk("t3 core_reset held", core_reset, 1);
      chk("t3 in_ready held",   in_ready,   0);
      chk("t3 no writes",       wr_q.size(), 0);

      // One word with random valid gaps.
      do_reset("t4");
      new_test();
      words = '{32'hDEAD_BEEF};
      build_stream(1);
      send(stream.size(), 1'b1);
      check_load("t4", 1);

      // Reset mid-word, then a fresh load from BASE.
      do_reset("t5a");
      new_test();
      words = '{$urandom, $urandom, $urandom};
      build_stream(3);
      send(4, 1'b0);
      do_reset("t5b");
      chk("t5 partial no write", wr_q.size(), 0);
      new_test();
      words = '{$urandom, $urandom};
      build_stream(2);
      send(stream.size(), 1'b0);
      check_load("t5", 2);

      // Reload from DONE.
      pulse_load_req("t6");
      words = '{32'h8C01_0000};
      build_stream(1);
      send(stream.size(), 1'b0);
      check_load("t6", 1);

      // Random reloads with random gaps.
      for (int r = 0; r < 3; r++) begin
         pulse_load_req($sformatf("t7.%0d", r));
         n = $urandom_range(1, 8);
         words.delete();
         for (int k = 0; k < n; k++) words.push_back($urandom);
         build_stream(n);
         send(stream.size(), 1'($urandom_range(0, 1)));
         check_load($sformatf("t7.%0d", r), n);
      end

      // Exactly DEPTH words is legal.
      do_reset("t8");
      new_test();
      words.delete();
      for (int k = 0; k < int'(DEPTH); k++) words.push_back($urandom);
      build_stream(int'(DEPTH));
      send(stream.size(), 1'b0);
      check_load("t8", int'(DEPTH));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
